memory_arbiter: RTL and testbench
=================================

// Module: memory_arbiter
// PURPOSE
//  Shares one single-port RAM between CPUS cores; each core has an I-fetch and a D-access requester.
//  Sits between the per-core caches and the RAM model, on the RAM-facing side of the memory controller.
//  Round-robin across cores; inside a core, D beats I. Owns one RAM transaction at a time.
//  Watchdog aborts a transaction that never reaches ACCESS.
// PARAMETERS
//  CPUS     2    number of cores (>=1); requester index = {cpu, isD}
//  TIMEOUT  255  max cycles in BUSY before abort (>=4); counter width $clog2(TIMEOUT+1)
// PORTS
//  CLK          in   1        clock, all state updates on posedge
//  nRST         in   1        synchronous, active-low reset
//  iREN         in   CPUS     instruction read request, per core
//  dREN         in   CPUS     data read request, per core
//  dWEN         in   CPUS     data write request, per core
//  iaddr        in   CPUSx32  instruction address, per core
//  daddr        in   CPUSx32  data address, per core
//  dstore       in   CPUSx32  data write value, per core
//  iwait        out  CPUS     0 = instruction ready this cycle
//  dwait        out  CPUS     0 = data access complete this cycle
//  iload        out  CPUSx32  instruction return (ramload broadcast)
//  dload        out  CPUSx32  data return (ramload broadcast)
//  ramload      in   32       RAM read data
//  ramstate     in   2        ramstate_t: FREE/BUSY/ACCESS/ERROR
//  ramREN       out  1        RAM read enable
//  ramWEN       out  1        RAM write enable
//  ramaddr      out  32       RAM address
//  ramstore     out  32       RAM write data
//  arb_timeout  out  1        one-cycle pulse on watchdog abort
// BEHAVIOUR
//  - Reset (nRST=0 at posedge): state=IDLE, rr_ptr=0, grant=0, wdog=0, arb_timeout=0.
//    Combinational outputs in IDLE: ramREN=ramWEN=0, ramaddr=ramstore=0, all iwait/dwait=1.
//  - FSM IDLE -> BUSY -> IDLE.
//  - IDLE: scan cores rr_ptr, rr_ptr+1, ... (mod CPUS); take the first core with any request.
//    Inside that core: D (dREN|dWEN) before I. Latch grant {cpu, isD}. Go BUSY; wdog=0.
//    No request: stay IDLE.
//  - BUSY drives the RAM from the live inputs of the granted requester:
//    D: ramaddr=daddr; ramREN=dREN; ramWEN=dWEN&~dREN (read wins if both); ramstore=dstore.
//    I: ramaddr=iaddr, ramREN=1.
//  - Completion: BUSY and ramstate==ACCESS -> granted wait=0 in that same cycle (combinational).
//    Next state IDLE; rr_ptr=grant.cpu+1 mod CPUS. Every other wait stays 1.
//  - Request dropped in BUSY (granted enables all 0): abort to IDLE, no wait deassert, rr_ptr unchanged.
//  - ERROR or BUSY/FREE ramstate: hold the request, wdog++.
//    wdog==TIMEOUT -> arb_timeout=1 for one cycle, IDLE, rr_ptr advances past the offender.
//  - Latency: request in cycle N (IDLE) -> RAM enable from cycle N+1 -> wait low in the first ACCESS cycle.
//    At least one idle cycle between back-to-back grants.
//  - A request arriving in BUSY waits; requests are never dropped.
//  - Requesters hold addr/data stable until their wait is low.
//  - iload[i]=dload[i]=ramload for all i; consumers qualify with their wait.
//  - Reset mid-BUSY: RAM enables drop in the cycle after the reset edge; no completion reported.
// STRUCTURE
//  - Package cpu_types_pkg already holds word_t and ramstate_t.
//  - Add to it: arb_state_t {IDLE, BUSY} and typedef struct packed {logic [$clog2(CPUS)-1:0] cpu; logic isD;} arb_grant_t.
//  - One sub-module: rr_picker (comb): req[CPUS], ptr -> valid, idx. The rest is a flat FSM plus the watchdog counter.
// TESTING
//  1 Reset: nRST=0 for 2 clk with all requests high -> ramREN=ramWEN=0, iwait=dwait=2'b11.
//  2 Single fetch: iREN[0]=1, iaddr[0]=0x40, RAM gives ACCESS after 2 BUSY cycles.
//    -> ramaddr=0x40 from N+1, iwait[0]=0 for exactly 1 cycle, iload[0]=ramload.
//  3 D over I: core0 dREN=1 daddr=0x100 and iREN=1 in the same cycle -> D served first, then I.
//    dwait[0] falls before iwait[0].
//  4 Round-robin: both cores iREN=1 continuously -> grant order core0, core1, core0, core1; no starvation.
//  5 Read/write conflict: dREN=dWEN=1 -> ramREN=1, ramWEN=0.
//    Write: dWEN[1]=1, dstore=0xDEADBEEF -> ramstore=0xDEADBEEF, ramWEN=1.
//  6 Watchdog (TIMEOUT=8): ramstate stuck BUSY -> arb_timeout pulses on the 9th BUSY cycle, then IDLE.
//    rr_ptr moves to the next core; a mid-BUSY reset also leaves wait high.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared cpu/memory types plus the memory arbiter state, grant and helpers
package cpu_types_pkg;
   typedef logic [31:0] word_t;
   typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
   localparam int CPUS_N = 2;
   localparam int CPU_W = CPUS_N > 1 ? $clog2(CPUS_N) : 1;
   typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;
   typedef struct packed {logic [CPU_W-1:0] cpu; logic isD;} arb_grant_t;
   function automatic logic [CPU_W-1:0] next_cpu(input logic [CPU_W-1:0] c, input int n);
      return CPU_W'((int'(c) + 1) % n);
   endfunction
endpackage

// File: rtl/memory_arbiter_rr_picker.sv
// rr_picker: first requesting core at or after ptr, wrapping modulo CPUS
module rr_picker
   import cpu_types_pkg::*;
#(
   parameter int CPUS = CPUS_N
) (
   input  logic [CPUS-1:0]  req,
   input  logic [CPU_W-1:0] ptr,
   output logic             valid,
   output logic [CPU_W-1:0] idx
);
   always_comb begin
      valid = 1'b0;
      idx = '0;
      for (int k = CPUS - 1; k >= 0; k--) begin
         if (req[CPU_W'((int'(ptr) + k) % CPUS)]) begin
            valid = 1'b1;
            idx = CPU_W'((int'(ptr) + k) % CPUS);
         end
      end
   end
endmodule

// File: rtl/memory_arbiter.sv
// memory_arbiter: round-robin single-port RAM arbiter for per-core I/D requesters with a watchdog
module memory_arbiter
   import cpu_types_pkg::*;
#(
   parameter int CPUS = CPUS_N,
   parameter int TIMEOUT = 255
) (
   input  logic                  CLK,
   input  logic                  nRST,
   input  logic [CPUS-1:0]       iREN,
   input  logic [CPUS-1:0]       dREN,
   input  logic [CPUS-1:0]       dWEN,
   input  logic [CPUS-1:0][31:0] iaddr,
   input  logic [CPUS-1:0][31:0] daddr,
   input  logic [CPUS-1:0][31:0] dstore,
   output logic [CPUS-1:0]       iwait,
   output logic [CPUS-1:0]       dwait,
   output logic [CPUS-1:0][31:0] iload,
   output logic [CPUS-1:0][31:0] dload,
   input  logic [31:0]           ramload,
   input  logic [1:0]            ramstate,
   output logic                  ramREN,
   output logic                  ramWEN,
   output logic [31:0]           ramaddr,
   output logic [31:0]           ramstore,
   output logic                  arb_timeout
);
   localparam int WW = $clog2(TIMEOUT + 1);
   arb_state_t state, nstate;
   arb_grant_t grant, ngrant;
   logic [CPU_W-1:0] rr_ptr, nptr, pick_idx;
   logic [WW-1:0] wdog, nwdog;
   logic pick_valid, busy, g_dren, g_dwen, live, done;
   rr_picker #(.CPUS(CPUS)) u_pick (
      .req(iREN | dREN | dWEN),
      .ptr(rr_ptr),
      .valid(pick_valid),
      .idx(pick_idx)
   );
   assign busy = state == ARB_BUSY;
   assign g_dren = dREN[grant.cpu];
   assign g_dwen = dWEN[grant.cpu];
   assign live = grant.isD ? g_dren | g_dwen : iREN[grant.cpu];
   assign done = busy & live & (ramstate == ACCESS);
   assign arb_timeout = busy & live & (ramstate != ACCESS) & (wdog == WW'(TIMEOUT));
   // RAM is driven from the granted requester's live inputs; read wins over write
   assign ramREN = busy & (grant.isD ? g_dren : iREN[grant.cpu]);
   assign ramWEN = busy & grant.isD & g_dwen & ~g_dren;
   assign ramaddr = busy ? (grant.isD ? daddr[grant.cpu] : iaddr[grant.cpu]) : '0;
   assign ramstore = busy & grant.isD ? dstore[grant.cpu] : '0;
   assign iload = {CPUS{ramload}};
   assign dload = {CPUS{ramload}};
   always_comb begin
      iwait = '1;
      dwait = '1;
      iwait[grant.cpu] = ~(done & ~grant.isD);
      dwait[grant.cpu] = ~(done & grant.isD);
   end
   always_comb begin
      nstate = state;
      ngrant = grant;
      nptr = rr_ptr;
      nwdog = wdog;
      if (!busy) begin
         if (pick_valid) begin
            nstate = ARB_BUSY;
            ngrant = {pick_idx, dREN[pick_idx] | dWEN[pick_idx]};
            nwdog = '0;
         end
      end else if (!live) nstate = ARB_IDLE;
      else if (done | arb_timeout) begin
         nstate = ARB_IDLE;
         nptr = next_cpu(grant.cpu, CPUS);
      end else nwdog = wdog + 1'b1;
   end
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state <= ARB_IDLE;
         grant <= '0;
         rr_ptr <= '0;
         wdog <= '0;
      end else begin
         state <= nstate;
         grant <= ngrant;
         rr_ptr <= nptr;
         wdog <= nwdog;
      end
   end
endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: directed checks of reset, latency, D-over-I, round-robin, r/w conflict, drop and watchdog
module tb_memory_arbiter;
   import cpu_types_pkg::*;
   logic CLK, nRST;
   logic [1:0] iREN, dREN, dWEN, iwait, dwait;
   logic [1:0][31:0] iaddr, daddr, dstore, iload, dload;
   logic [31:0] ramload, ramaddr, ramstore;
   logic [1:0] ramstate;
   logic ramREN, ramWEN, arb_timeout;
   int n_cmp = 0, n_err = 0;

   memory_arbiter #(.CPUS(2), .TIMEOUT(8)) dut (
      .CLK(CLK), .nRST(nRST),
      .iREN(iREN), .dREN(dREN), .dWEN(dWEN),
      .iaddr(iaddr), .daddr(daddr), .dstore(dstore),
      .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
      .ramload(ramload), .ramstate(ramstate),
      .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
      .arb_timeout(arb_timeout)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   initial begin
      nRST = 1'b0;
      iREN = '1; dREN = '1; dWEN = '1;
      iaddr = '0; daddr = '0; dstore = '0;
      ramload = 32'h0; ramstate = FREE;
      tick;
      tick;
      chk("rst_ren", ramREN, 0);
      chk("rst_wen", ramWEN, 0);
      chk("rst_iwait", iwait, 2'b11);
      chk("rst_dwait", dwait, 2'b11);
      chk("rst_addr", ramaddr, 0);
      chk("rst_tmo", arb_timeout, 0);
      // single fetch, ACCESS on the third BUSY cycle
      nRST = 1'b1;
      iREN = 2'b01; dREN = '0; dWEN = '0;
      iaddr[0] = 32'h40; ramstate = BUSY;
      #1;
      chk("if_idle_ren", ramREN, 0);
      tick;
      chk("if_ren", ramREN, 1);
      chk("if_addr", ramaddr, 32'h40);
      chk("if_wait_b1", iwait, 2'b11);
      tick;
      chk("if_wait_b2", iwait, 2'b11);
      tick;
      ramstate = ACCESS; ramload = 32'h1234_5678;
      #1;
      chk("if_done", iwait, 2'b10);
      chk("if_dwait", dwait, 2'b11);
      chk("if_iload", iload[0], 32'h1234_5678);
      chk("if_dload", dload[1], 32'h1234_5678);
      tick;
      iREN = '0; ramstate = FREE;
      #1;
      chk("if_one_cycle", iwait, 2'b11);
      chk("if_gap", ramREN, 0);
      // D beats I inside core0
      dREN = 2'b01; daddr[0] = 32'h100; iREN = 2'b01; iaddr[0] = 32'h200;
      #1;
      tick;
      chk("dv_addr", ramaddr, 32'h100);
      chk("dv_ren", ramREN, 1);
      chk("dv_wen", ramWEN, 0);
      ramstate = ACCESS;
      #1;
      chk("dv_dwait", dwait, 2'b10);
      chk("dv_iwait", iwait, 2'b11);
      tick;
      dREN = '0; ramstate = FREE;
      #1;
      chk("dv_gap", ramREN, 0);
      chk("dv_gap_iwait", iwait, 2'b11);
      tick;
      chk("dv_iaddr", ramaddr, 32'h200);
      ramstate = ACCESS;
      #1;
      chk("dv_idone", iwait, 2'b10);
      tick;
      iREN = '0;
      // round-robin from a fresh pointer
      nRST = 1'b0;
      tick;
      nRST = 1'b1;
      iREN = 2'b11; iaddr[0] = 32'h300; iaddr[1] = 32'h400; ramstate = ACCESS;
      #1;
      for (int g = 0; g < 4; g++) begin
         tick;
         chk("rr_addr", ramaddr, (g % 2) != 0 ? 32'h400 : 32'h300);
         chk("rr_iwait", iwait, (g % 2) != 0 ? 2'b01 : 2'b10);
         tick;
         chk("rr_gap", ramREN, 0);
      end
      iREN = '0;
      // read/write conflict then plain write on core1
      ramstate = BUSY; dREN = 2'b10; dWEN = 2'b10; daddr[1] = 32'h500;
      #1;
      tick;
      chk("rw_ren", ramREN, 1);
      chk("rw_wen", ramWEN, 0);
      chk("rw_addr", ramaddr, 32'h500);
      ramstate = ACCESS;
      #1;
      chk("rw_dwait", dwait, 2'b01);
      tick;
      dREN = '0; dWEN = 2'b10; dstore[1] = 32'hDEAD_BEEF; daddr[1] = 32'h504;
      #1;
      chk("wr_idle_wen", ramWEN, 0);
      tick;
      chk("wr_wen", ramWEN, 1);
      chk("wr_ren", ramREN, 0);
      chk("wr_store", ramstore, 32'hDEAD_BEEF);
      chk("wr_addr", ramaddr, 32'h504);
      chk("wr_dwait", dwait, 2'b01);
      tick;
      dWEN = '0;
      // request dropped while BUSY aborts silently
      iREN = 2'b01; iaddr[0] = 32'h80; ramstate = BUSY;
      #1;
      tick;
      chk("drop_ren", ramREN, 1);
      iREN = '0;
      #1;
      chk("drop_ren_off", ramREN, 0);
      chk("drop_iwait", iwait, 2'b11);
      tick;
      chk("drop_idle", ramREN, 0);
      // watchdog: stuck BUSY, pulse on the 9th BUSY cycle
      iREN = 2'b01; iaddr[0] = 32'h600; ramstate = BUSY;
      #1;
      chk("wd_idle", arb_timeout, 0);
      for (int k = 1; k <= 9; k++) begin
         tick;
         chk("wd_pulse", arb_timeout, k == 9);
         chk("wd_iwait", iwait, 2'b11);
      end
      iREN = 2'b11; iaddr[1] = 32'h700;
      tick;
      chk("wd_after", arb_timeout, 0);
      chk("wd_idle_ren", ramREN, 0);
      tick;
      chk("wd_rr_next", ramaddr, 32'h700);
      // reset in the middle of BUSY
      nRST = 1'b0;
      tick;
      ramstate = ACCESS;
      #1;
      chk("mrst_ren", ramREN, 0);
      chk("mrst_iwait", iwait, 2'b11);
      chk("mrst_dwait", dwait, 2'b11);
      nRST = 1'b1; iREN = '0;
      tick;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
